// File: rtl/alu_pkg.sv
// Shared definitions for the iterative execution unit: operation encoding,
// default widths, FSM state encoding and small decode helpers.
package alu_pkg;

    localparam int ALU_WIDTH   = 32;
    localparam int ALU_SHAMT_W = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLL  = 4'b0101,
        OP_SRL  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_SLTU = 4'b1000,
        OP_SLT  = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Encodings 1010..1111 are not assigned to any operation.
    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_SLT;
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Bit-serial shifter: loads an accumulator and a down-counter on start, then
// shifts one position per cycle until the counter reaches zero.
module alu_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               left_i,
    input  logic               arith_i,
    input  logic [WIDTH-1:0]   load_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               done_o,
    output logic [WIDTH-1:0]   value_o
);

    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;
    logic [SHAMT_W-1:0] cnt_q;
    logic               left_q;
    logic               arith_q;

    // One-position shift of the accumulator; under SRA the MSB never changes,
    // so replicating it reproduces the original sign of the operand.
    always_comb begin
        acc_d = acc_q;
        if (left_q) begin
            acc_d = {acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_d = {(arith_q & acc_q[WIDTH-1]), acc_q[WIDTH-1:1]};
        end
    end

    // Remaining-shift counter; reset clears it so an aborted shift stops.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q <= shamt_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - SHAMT_W'(1);
        end
    end

    // Accumulator and direction capture; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (start_i) begin
            acc_q   <= load_i;
            left_q  <= left_i;
            arith_q <= arith_i;
        end else if (cnt_q != '0) begin
            acc_q   <= acc_d;
        end
    end

    // The last shift happens in the cycle the counter reads 1; the caller
    // captures the post-shift value on that same edge.
    assign done_o  = (cnt_q == SHAMT_W'(1));
    assign value_o = acc_d;

endmodule

// File: rtl/alu_iter.sv
// Handshaked multi-cycle integer execution unit: single-cycle arithmetic,
// logic and compare ops, iterative shifts, registered result toward writeback.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    alu_state_e         state_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               err_q;
    logic [WIDTH-1:0]   op_res;
    logic               accept;
    logic               shift_op;
    logic [SHAMT_W-1:0] shamt;
    logic               sh_start;
    logic               sh_done;
    logic [WIDTH-1:0]   sh_value;

    // Reset is folded in so nothing can be accepted while rst is high.
    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign shift_op = is_shift(alu_op);
    assign shamt    = b[SHAMT_W-1:0];
    assign sh_start = accept && shift_op && (shamt != '0);

    // Single-cycle operations computed straight from the accepted operands.
    always_comb begin
        op_res = '0;
        case (alu_op)
            OP_ADD:  op_res = a + b;
            OP_SUB:  op_res = a - b;
            OP_AND:  op_res = a & b;
            OP_OR:   op_res = a | b;
            OP_XOR:  op_res = a ^ b;
            OP_SLTU: op_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: op_res = '0;
        endcase
    end

    alu_shift_unit #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .start_i (sh_start),
        .left_i  (alu_op == OP_SLL),
        .arith_i (alu_op == OP_SRA),
        .load_i  (a),
        .shamt_i (shamt),
        .done_o  (sh_done),
        .value_o (sh_value)
    );

    // Control FSM with registered result, error flag and output valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (!is_legal(alu_op)) begin
                            result_q    <= '0;
                            err_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else if (shift_op && (shamt != '0)) begin
                            state_q     <= ST_SHIFT;
                        end else if (shift_op) begin
                            result_q    <= a;
                            err_q       <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            result_q    <= op_res;
                            err_q       <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (sh_done) begin
                        result_q    <= sh_value;
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err       = err_q;

endmodule

// File: doc/alu_iter.md
# alu_iter

Handshaked, multi-cycle integer execution unit for the RISC-V datapath, using the same 4-bit operation encoding as the combinational ALU. Accepts one operation at a time over a valid/ready input channel. Arithmetic, logic and compare ops finish in one cycle; shifts run iteratively, one bit position per cycle, to save area. The registered result goes out on a valid/ready output channel toward writeback.

## Interface
- `WIDTH`, 32: operand/result width.
- `SHAMT_W`, 5: shift-amount width, log2(WIDTH).
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operation presented.
- `in_ready` out 1: unit can accept; asserted only in IDLE.
- `alu_op` in 4: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLTU, 1001 SLT; 1010–1111 illegal.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B; for shifts only b[SHAMT_W-1:0] is used.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes result.
- `result` out WIDTH: registered result.
- `err` out 1: illegal opcode flag, qualified by out_valid.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, inputs are captured and the op is decoded.
  - Non-shift legal op: compute, load result, go to DONE.
  - Shift op: load accumulator=a and count=b[4:0]. If count==0, go to DONE with result=a. Otherwise go to SHIFT.
  - Illegal op: result=0, err=1, go to DONE.
- SHIFT:
  - Each cycle, shift the accumulator by 1 and decrement count.
  - SLL fills 0 at bit 0. SRL fills 0 at the MSB. SRA fills with the original a[WIDTH-1].
  - When count goes 1→0, result=accumulator and go to DONE.
  - in_ready=0 throughout.
- DONE:
  - out_valid=1. result and err are held stable until out_valid&&out_ready, then go to IDLE.
  - in_ready=0; no overlap with a new accept.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
  - SLT is a signed compare, SLTU unsigned; result is zero-extended 0 or 1.
  - Upper bits b[31:5] are ignored for shifts.
- Inputs are sampled only on the accept cycle; later changes on a/b/alu_op have no effect.

## Timing
- Reset values: state=IDLE, out_valid=0, result=0, err=0.
- in_ready=0 while rst is high; in_ready=1 in the first cycle after rst deasserts.
- Latency, with accept in cycle T:
  - Non-shift, illegal, or shift-by-0: out_valid high in T+1.
  - Shift by n (1..31): out_valid high in T+1+n.
- Throughput: at most one op per 2 cycles (accept, then DONE handshake). The next accept is possible in the cycle after the output handshake.
- out_ready held low: DONE is held indefinitely with no change to result.
- out_ready high in the first DONE cycle: single-cycle DONE.
- Reset mid-SHIFT or in DONE: operation is discarded. IDLE next cycle, out_valid=0, and no result is ever presented.
- Simultaneous rst and in_valid: reset wins; nothing is accepted.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_e` enum with the ten encodings above.
  - `ALU_WIDTH=32`, `ALU_SHAMT_W=5`.
  - Helper `is_shift(op)`.
- One sub-module `alu_shift_unit`:
  - Holds the accumulator and down-counter.
  - Ports: start, dir/arith select, load value, shamt, done, value.
- The top holds the FSM, the single-cycle ops and the output register.

## Test plan
- ADD a=10, b=5 accepted at T, out_ready=1 → result=0x0000000F, err=0, out_valid only in T+1. Repeat SUB → 0x00000005. Repeat SUB a=5, b=10 → 0xFFFFFFFB.
- AND/OR/XOR with a=0xFF00FF00, b=0x0F0F0F0F → 0x0F000F00 / 0xFF0FFF0F / 0xF00FF00F.
- Shifts (check out_valid cycle for each):
  - SLL a=1, b=3 → 0x00000008 at T+4.
  - SRL a=16, b=0x00000022 (shamt 2) → 0x00000004 at T+3.
  - SRA a=0xFFFFFFF0, b=2 → 0xFFFFFFFC.
  - SLL by 0 → a at T+1.
- SLT a=0xFFFFFFFF, b=1 → 1. SLTU with the same operands → 0. alu_op=1111 → result=0, err=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. result stays stable, in_ready=0, and in_valid pulses are ignored. After the handshake, in_ready=1 the next cycle.
- Reset mid-op: SLL a=1, b=31, assert rst 3 cycles after accept → out_valid never rises, in_ready=1 the cycle after rst drops. A following ADD 2+2 → 0x00000004.
